ser_arb: RTL

- Round-robin arbiter and sequencer that shares one serializer instance between N_REQ requesters.
- Accepts a parallel word and length from each requester over a valid/ack handshake.
- Issues one word at a time to the serializer as a single-cycle data-valid pulse, then waits for the serializer to finish before granting again.
- Sits between the packet sources and the serializer; owner_o lets downstream logic demultiplex the serial stream.

---
 rtl/ser_arb_pkg.sv | 5 +
 rtl/ser_arb_rr_pick.sv | 19 +
 rtl/ser_arb.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ser_arb_pkg.sv
// ser_arb_pkg: FSM state type and default minimum word length shared by ser_arb.
package ser_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;
    localparam int MIN_MOD_DEF = 3;
endpackage

// File: rtl/ser_arb_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or above ptr_i with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    // Scan from the far end so the candidate closest to the pointer is written last.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) idx_o = IW'((int'(ptr_i) + i) % N);
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/ser_arb.sv
// ser_arb: round-robin arbiter handing one word per grant to a shared serializer.
// Define SER_ARB_TIMEOUT_EN to abandon a transfer when the serializer never reports busy.
module ser_arb
    import ser_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int MOD_W   = $clog2(WIDTH),
    parameter int MIN_MOD = MIN_MOD_DEF,
    parameter int TIMEOUT = 8,
    localparam int IW     = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    input  logic [N_REQ*MOD_W-1:0] req_mod_i,
    input  logic [N_REQ-1:0]       req_val_i,
    output logic [N_REQ-1:0]       req_ack_o,
    output logic [WIDTH-1:0]       ser_data_o,
    output logic [MOD_W-1:0]       ser_mod_o,
    output logic                   ser_val_o,
    input  logic                   ser_busy_i,
    output logic [IW-1:0]          owner_o,
    output logic                   owner_val_o,
    output logic                   drop_o,
    output logic                   err_o
);
    state_e             state_q;
    logic [IW-1:0]      ptr_q, ptr_d, pick, owner_q;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]   data_q;
    logic [MOD_W-1:0]   mod_q;
    logic               any, short_d, val_q, owner_val_q, drop_q;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req_i (req_val_i),
        .ptr_i (ptr_q),
        .idx_o (pick),
        .any_o (any)
    );

    assign ptr_d   = (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;
    assign ack_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
    assign short_d = int'(req_mod_i[int'(pick)*MOD_W +: MOD_W]) < MIN_MOD;

`ifdef SER_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            ack_q       <= '0;
            data_q      <= '0;
            mod_q       <= '0;
            val_q       <= 1'b0;
            owner_val_q <= 1'b0;
            drop_q      <= 1'b0;
`ifdef SER_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            ack_q  <= '0;
            val_q  <= 1'b0;
            drop_q <= 1'b0;
`ifdef SER_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: if (!ser_busy_i && any) begin
                    ack_q <= ack_d;
                    ptr_q <= ptr_d;
                    if (short_d) drop_q <= 1'b1;
                    else begin
                        data_q      <= req_data_i[int'(pick)*WIDTH +: WIDTH];
                        mod_q       <= req_mod_i[int'(pick)*MOD_W +: MOD_W];
                        val_q       <= 1'b1;
                        owner_q     <= pick;
                        owner_val_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_BUSY;
`ifdef SER_ARB_TIMEOUT_EN
                    cnt_q   <= CW'(1);
`endif
                end
                WAIT_BUSY: begin
                    if (ser_busy_i) state_q <= WAIT_DONE;
`ifdef SER_ARB_TIMEOUT_EN
                    else if (int'(cnt_q) >= TIMEOUT - 1) begin
                        err_q       <= 1'b1;
                        owner_val_q <= 1'b0;
                        state_q     <= IDLE;
                    end else cnt_q <= cnt_q + 1'b1;
`endif
                end
                WAIT_DONE: if (!ser_busy_i) begin
                    owner_val_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ack_o   = ack_q;
    assign ser_data_o  = data_q;
    assign ser_mod_o   = mod_q;
    assign ser_val_o   = val_q;
    assign owner_o     = owner_q;
    assign owner_val_o = owner_val_q;
    assign drop_o      = drop_q;
endmodule
